// File: rtl/obi_burst_bridge.sv
// Bridges the ibex instruction and data OBI ports onto one line-oriented burst memory port.
// One access in flight; loads fetch a whole line, stores read-modify-write the whole line.
module obi_burst_bridge #(
    parameter int ADDR_W     = 32,
    parameter int BEAT_W     = 64,
    parameter int LINE_BEATS = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [ADDR_W-1:0] instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [31:0]       instr_rdata_o,
    output logic [6:0]        instr_rdata_intg_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [31:0]       data_rdata_o,
    output logic [6:0]        data_rdata_intg_o,
    output logic              data_err_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [BEAT_W-1:0] mem_wdata_o,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    input  logic              mem_resp_i,
    output logic [1:0]        dbg_state_o
);
    localparam int LINE_W = BEAT_W * LINE_BEATS;
    localparam int WORDS  = LINE_W / 32;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WSEL_W = OFF_W - 2;
    localparam int CNT_W  = $clog2(LINE_BEATS);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_t;

    state_t                              state_q;
    logic                                src_data_q;
    logic                                we_q;
    logic [3:0]                          be_q;
    logic [31:0]                         wdata_q;
    logic [WSEL_W-1:0]                   wsel_q;
    logic [CNT_W-1:0]                    cnt_q;
    logic [31:0]                         rdata_q;
    logic [LINE_BEATS-1:0][BEAT_W-1:0]   line_q;
    logic [LINE_BEATS-1:0][BEAT_W-1:0]   line_fill;
    logic [WORDS-1:0][31:0]              fill_words;
    logic [WORDS*4-1:0][7:0]             merge_bytes;
    logic [ADDR_W-1:0]                   sel_addr;
    logic                                last_beat;
    logic                                unused_addr;

    // OBI: a request is accepted in the cycle req && gnt; its single response is the
    // one-cycle rvalid pulse. Memory: mem_resp_i strobes one beat while read/write is held.
    assign data_gnt_o  = (state_q == IDLE) && data_req_i;
    assign instr_gnt_o = (state_q == IDLE) && instr_req_i && !data_req_i;

    assign sel_addr    = data_req_i ? data_addr_i : instr_addr_i;
    assign unused_addr = ^sel_addr[1:0];
    assign last_beat   = mem_resp_i && (cnt_q == CNT_W'(LINE_BEATS - 1));

    assign instr_rdata_o      = rdata_q;
    assign data_rdata_o       = rdata_q;
    assign instr_rdata_intg_o = '0;
    assign data_rdata_intg_o  = '0;
    assign instr_err_o        = 1'b0;
    assign data_err_o         = 1'b0;
    assign dbg_state_o        = state_q;
    assign mem_wdata_o        = (state_q == WR_BURST) ? line_q[cnt_q] : '0;

    // Line as it looks once the beat currently on mem_rdata_i is included.
    always_comb begin
        line_fill        = line_q;
        line_fill[cnt_q] = mem_rdata_i;
    end

    assign fill_words = line_fill;

    always_comb begin
        merge_bytes = line_fill;
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
                merge_bytes[{wsel_q, 2'(b)}] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            src_data_q     <= 1'b0;
            we_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            wsel_q         <= '0;
            cnt_q          <= '0;
            line_q         <= '0;
            rdata_q        <= '0;
            instr_rvalid_o <= 1'b0;
            data_rvalid_o  <= 1'b0;
            mem_read_o     <= 1'b0;
            mem_write_o    <= 1'b0;
            mem_addr_o     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_req_i || instr_req_i) begin
                        src_data_q <= data_req_i;
                        we_q       <= data_req_i && data_we_i;
                        be_q       <= data_be_i;
                        wdata_q    <= data_wdata_i;
                        wsel_q     <= sel_addr[OFF_W-1:2];
                        cnt_q      <= '0;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= {sel_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        state_q    <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (last_beat) begin
                        mem_read_o <= 1'b0;
                        cnt_q      <= '0;
                        if (we_q) begin
                            line_q      <= merge_bytes;
                            mem_write_o <= 1'b1;
                            state_q     <= WR_BURST;
                        end else begin
                            line_q         <= line_fill;
                            rdata_q        <= fill_words[wsel_q];
                            instr_rvalid_o <= !src_data_q;
                            data_rvalid_o  <= src_data_q;
                            state_q        <= RESP;
                        end
                    end else if (mem_resp_i) begin
                        line_q <= line_fill;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                end
                WR_BURST: begin
                    if (last_beat) begin
                        mem_write_o    <= 1'b0;
                        cnt_q          <= '0;
                        rdata_q        <= '0;
                        instr_rvalid_o <= !src_data_q;
                        data_rvalid_o  <= src_data_q;
                        state_q        <= RESP;
                    end else if (mem_resp_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    instr_rvalid_o <= 1'b0;
                    data_rvalid_o  <= 1'b0;
                    rdata_q        <= '0;
                    state_q        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_obi_burst_bridge.sv
// Directed bench for obi_burst_bridge: a small line memory answers bursts from tasks
// and every observation goes through one checking task.
module tb_obi_burst_bridge;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_rdata;
    logic [6:0]  instr_intg;
    logic        data_req, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid, data_err;
    logic [31:0] data_rdata;
    logic [6:0]  data_intg;
    logic        mem_read, mem_write, mem_resp;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;

    logic [63:0] mem_beats [64];
    logic [31:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    obi_burst_bridge dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .instr_rdata_intg_o(instr_intg), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .data_rdata_intg_o(data_intg), .data_err_o(data_err),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected beat b of a line after a store of wdata/be at addr.
    function automatic logic [63:0] merge_beat(input logic [63:0] old, input int b,
                                              input logic [31:0] addr, input logic [3:0] be,
                                              input logic [31:0] wdata);
        logic [63:0] r;
        int          base;
        r = old;
        if (int'(addr[4:3]) == b) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    base = (addr[2] ? 32 : 0) + 8 * k;
                    r[base +: 8] = wdata[8*k +: 8];
                end
            end
        end
        return r;
    endfunction

    // Starts on a falling edge in IDLE, ends on the falling edge after the RESP cycle.
    task automatic txn(input bit is_data, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata, input int gap,
                       input logic [31:0] exp_rdata, input bit hold_instr);
        logic [63:0] exp_wbeat [4];
        int          li;
        int          gap_b;
        li = int'(addr[8:5]);
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_be = be;
            data_addr = addr; data_wdata = wdata;
        end else begin
            instr_req = 1'b1; instr_addr = addr;
        end
        exp_q.push_back(we ? 32'h0 : exp_rdata);
        for (int b = 0; b < 4; b++) exp_wbeat[b] = merge_beat(mem_beats[li*4+b], b, addr, be, wdata);
        #1;
        check("data_gnt", data_gnt, is_data);
        check("instr_gnt", instr_gnt, !is_data);
        @(negedge clk);
        data_req = 1'b0;
        if (!hold_instr) instr_req = 1'b0;
        #1;
        check("rd_start", {mem_read, mem_write}, 2'b10);
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFE0);
        check("gnt_busy", {instr_gnt, data_gnt}, 2'b00);
        for (int b = 0; b < 4; b++) begin
            gap_b = (b % 2 == 1) ? gap : 0;
            repeat (gap_b) begin
                check("rd_hold", mem_read, 1'b1);
                @(negedge clk);
            end
            mem_resp = 1'b1; mem_rdata = mem_beats[li*4+b];
            @(negedge clk);
            mem_resp = 1'b0; mem_rdata = '0;
        end
        if (we) begin
            check("wr_start", {mem_read, mem_write}, 2'b01);
            for (int b = 0; b < 4; b++) begin
                gap_b = (b % 2 == 1) ? gap : 0;
                repeat (gap_b) begin
                    check("wr_hold", mem_write, 1'b1);
                    @(negedge clk);
                end
                check($sformatf("wbeat%0d", b), mem_wdata, exp_wbeat[b]);
                mem_beats[li*4+b] = mem_wdata;
                mem_resp = 1'b1;
                @(negedge clk);
                mem_resp = 1'b0;
            end
        end
        check("rvalid", {instr_rvalid, data_rvalid}, is_data ? 2'b01 : 2'b10);
        check("rdata", is_data ? data_rdata : instr_rdata, exp_q.pop_front());
        check("resp_mem_idle", {mem_read, mem_write}, 2'b00);
        @(negedge clk);
        check("rvalid_1cyc", {instr_rvalid, data_rvalid}, 2'b00);
    endtask

    initial begin
        logic [31:0] base;
        for (int l = 0; l < 16; l++) begin
            base = (l == 8) ? 32'hA000_0000 : (l == 9) ? 32'hB000_0000 : (32'(l) << 24);
            for (int b = 0; b < 4; b++)
                mem_beats[l*4+b] = {base + 32'(2*b + 1), base + 32'(2*b)};
        end
        rst_n = 1'b0; instr_req = 1'b0; instr_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_mem", {mem_read, mem_write}, 2'b00);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 64'h0);
        check("rst_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
        check("rst_rdata", {instr_rdata, data_rdata}, 64'h0);
        check("rst_state", dbg_state, 2'd0);
        check("tied_zero", {instr_err, data_err, instr_intg, data_intg}, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch word 5 of line 0x100.
        txn(1'b0, 1'b0, 4'h0, 32'h114, 32'h0, 0, 32'hA000_0005, 1'b0);

        // Store merge into word 2, low half-word only.
        @(negedge clk);
        txn(1'b1, 1'b1, 4'b0011, 32'h108, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        check("line_b0", mem_beats[8*4+0], 64'hA000_0001_A000_0000);
        check("line_b1", mem_beats[8*4+1], 64'hA000_0003_A000_BEEF);
        check("line_b2", mem_beats[8*4+2], 64'hA000_0005_A000_0004);
        check("line_b3", mem_beats[8*4+3], 64'hA000_0007_A000_0006);

        // Load back with addr[1:0] != 0 and 3-cycle memory stalls.
        @(negedge clk);
        txn(1'b1, 1'b0, 4'hF, 32'h10A, 32'h0, 3, 32'hA000_BEEF, 1'b0);

        // Both masters request: data first, fetch granted in the IDLE cycle after RESP.
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h120;
        txn(1'b1, 1'b0, 4'hF, 32'h11C, 32'h0, 0, 32'hA000_0007, 1'b1);
        txn(1'b0, 1'b0, 4'h0, 32'h120, 32'h0, 0, 32'hB000_0000, 1'b0);

        // Stalled fetch, then a be=0 store that must leave the line intact.
        @(negedge clk);
        txn(1'b0, 1'b0, 4'h0, 32'h128, 32'h0, 3, 32'hB000_0002, 1'b0);
        @(negedge clk);
        txn(1'b1, 1'b1, 4'b0000, 32'h130, 32'h1234_5678, 3, 32'h0, 1'b0);
        check("be0_b2", mem_beats[9*4+2], 64'hB000_0005_B000_0004);

        // Spurious beat strobes while idle.
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            check("spur_state", dbg_state, 2'd0);
            check("spur_out", {mem_read, mem_write, instr_rvalid, data_rvalid}, 4'h0);
        end
        mem_resp = 1'b0; mem_rdata = '0;
        txn(1'b0, 1'b0, 4'h0, 32'h11C, 32'h0, 0, 32'hA000_0007, 1'b0);

        // Reset after two beats of a fetch; remaining beats arrive and must be ignored.
        @(negedge clk);
        instr_req = 1'b1; instr_addr = 32'h100;
        @(negedge clk);
        instr_req = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_resp = 1'b1; mem_rdata = mem_beats[8*4+b];
            @(negedge clk);
        end
        rst_n = 1'b0; mem_rdata = mem_beats[8*4+2];
        @(negedge clk);
        check("rstmid_mem", {mem_read, mem_write}, 2'b00);
        check("rstmid_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
        check("rstmid_state", dbg_state, 2'd0);
        rst_n = 1'b1; mem_rdata = mem_beats[8*4+3];
        @(negedge clk);
        check("post_rst_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
        check("post_rst_state", dbg_state, 2'd0);
        mem_resp = 1'b0; mem_rdata = '0;
        txn(1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 0, 32'hA000_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
